// File: rtl/phase_sweep_pkg.sv
// Shared types and widths for the phase sweep controller and its dwell counter.
package phase_sweep_pkg;

  localparam int FREQ_W      = 5;
  localparam int ANGLE_W     = 24;
  localparam int DEF_DWELL_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/phase_sweep_dwell_counter.sv
// Load/decrement counter with a zero flag; load has priority, decrement saturates at 0.
module dwell_counter #(
  parameter int DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic               i_load,
  input  logic [DWELL_W-1:0] i_load_val,
  input  logic               i_dec,
  output logic [DWELL_W-1:0] o_count,
  output logic               o_zero
);

  logic [DWELL_W-1:0] count_q;

  // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      count_q <= '0;
    end else if (i_load) begin
      count_q <= i_load_val;
    end else if (i_dec && (count_q != '0)) begin
      count_q <= count_q - DWELL_W'(1);
    end
  end

  assign o_count = count_q;
  assign o_zero  = (count_q == '0);

endmodule

// File: rtl/phase_sweep_controller.sv
// Stepped frequency sweep sequencer driving the phase accumulator's freq/offset/enable.
// Optional continuous sweeping (i_loop port) is enabled by defining PHASE_SWEEP_LOOP_EN.
module phase_sweep_controller
  import phase_sweep_pkg::*;
#(
  parameter int DWELL_W = DEF_DWELL_W
) (
  input  logic               i_clk,
  input  logic               i_arst,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [FREQ_W-1:0]  i_freq_start,
  input  logic [FREQ_W-1:0]  i_freq_stop,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [ANGLE_W-1:0] i_offset,
`ifdef PHASE_SWEEP_LOOP_EN
  input  logic               i_loop,
`endif
  output logic [FREQ_W-1:0]  o_freq,
  output logic [ANGLE_W-1:0] o_offset,
  output logic               o_enable,
  output logic               o_busy,
  output logic               o_step,
  output logic               o_done
);

  state_t             state_q, state_d;
  logic [FREQ_W-1:0]  freq_q, stop_q;
  logic [ANGLE_W-1:0] offset_q;
  logic [DWELL_W-1:0] dwell_m1_q;
  logic               up_q, step_q;
  logic               cnt_zero, start_go, expire, last_code, loop_req;
  logic [DWELL_W-1:0] cnt_unused;

`ifdef PHASE_SWEEP_LOOP_EN
  logic [FREQ_W-1:0]  start_q;
  assign loop_req = i_loop;
`else
  assign loop_req = 1'b0;
`endif

  assign start_go  = (state_q == ST_IDLE) && i_start && !i_abort;
  assign expire    = (state_q == ST_RUN) && cnt_zero && !i_abort;
  assign last_code = (freq_q == stop_q);

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_go) state_d = ST_ARM;
      ST_ARM:  state_d = i_abort ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (i_abort)                           state_d = ST_IDLE;
        else if (expire && last_code && !loop_req) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Descriptor latch and frequency stepper; freq/offset hold on abort and after completion.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      freq_q     <= '0;
      stop_q     <= '0;
      offset_q   <= '0;
      dwell_m1_q <= '0;
      up_q       <= 1'b0;
      step_q     <= 1'b0;
`ifdef PHASE_SWEEP_LOOP_EN
      start_q    <= '0;
`endif
    end else begin
      step_q <= 1'b0;
      if (start_go) begin
        freq_q     <= i_freq_start;
        stop_q     <= i_freq_stop;
        offset_q   <= i_offset;
        up_q       <= (i_freq_start <= i_freq_stop);
        dwell_m1_q <= (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
`ifdef PHASE_SWEEP_LOOP_EN
        start_q    <= i_freq_start;
`endif
      end else if (expire) begin
        if (!last_code) begin
          freq_q <= up_q ? freq_q + FREQ_W'(1) : freq_q - FREQ_W'(1);
          step_q <= 1'b1;
        end
`ifdef PHASE_SWEEP_LOOP_EN
        else if (loop_req) begin
          freq_q <= start_q;
          step_q <= 1'b1;
        end
`endif
      end
    end
  end

  dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
    .i_clk      (i_clk),
    .i_arst     (i_arst),
    .i_load     (((state_q == ST_ARM) && !i_abort) || expire),
    .i_load_val (dwell_m1_q),
    .i_dec      ((state_q == ST_RUN) && !i_abort),
    .o_count    (cnt_unused),
    .o_zero     (cnt_zero)
  );

  // Status outputs decode the registered state only, so no input reaches an output combinationally.
  always_comb begin
    o_freq   = freq_q;
    o_offset = offset_q;
    o_step   = step_q;
    o_enable = (state_q == ST_RUN);
    o_busy   = (state_q == ST_ARM) || (state_q == ST_RUN);
    o_done   = (state_q == ST_DONE);
  end

endmodule

// File: tb/tb_phase_sweep_controller.sv
// Self-checking bench: table vectors, random sweeps vs. an arithmetic timeline model, corner sequences.
module tb_phase_sweep_controller;

  logic        i_clk = 1'b0;
  logic        i_arst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_abort = 1'b0;
  logic [4:0]  i_freq_start = '0;
  logic [4:0]  i_freq_stop = '0;
  logic [15:0] i_dwell = '0;
  logic [23:0] i_offset = '0;
`ifdef PHASE_SWEEP_LOOP_EN
  logic        i_loop = 1'b0;
`endif
  logic [4:0]  o_freq;
  logic [23:0] o_offset;
  logic        o_enable, o_busy, o_step, o_done;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  phase_sweep_controller #(.DWELL_W(16)) dut (
    .i_clk        (i_clk),
    .i_arst       (i_arst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_freq_start (i_freq_start),
    .i_freq_stop  (i_freq_stop),
    .i_dwell      (i_dwell),
    .i_offset     (i_offset),
`ifdef PHASE_SWEEP_LOOP_EN
    .i_loop       (i_loop),
`endif
    .o_freq       (o_freq),
    .o_offset     (o_offset),
    .o_enable     (o_enable),
    .o_busy       (o_busy),
    .o_step       (o_step),
    .o_done       (o_done)
  );

  typedef struct {
    int busy, enable, done, step, freq;
  } obs_t;

  typedef struct {
    string       name;
    int          fs, fe, d;
    logic [23:0] off;
    int          abort_at;
    int          exp_done;   // cycle of o_done, 0 = none
    int          exp_steps;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Expected observation t cycles after the start sample, from the timeline rules.
  function automatic obs_t model(int fs, int fe, int d, int t);
    obs_t o;
    int deff = (d == 0) ? 1 : d;
    int n    = ((fe >= fs) ? fe - fs : fs - fe) + 1;
    int dir  = (fe >= fs) ? 1 : -1;
    int last = 2 + n * deff;
    int k;
    o = '{0, 0, 0, 0, fe};
    if (t == 1) begin
      o.busy = 1; o.freq = fs;
    end else if (t >= 2 && t < last) begin
      k = (t - 2) / deff;
      o.busy = 1; o.enable = 1; o.freq = fs + dir * k;
      o.step = (((t - 2) % deff) == 0 && k > 0) ? 1 : 0;
    end else if (t == last) begin
      o.done = 1;
    end
    return o;
  endfunction

  function automatic int last_cycle(int fs, int fe, int d);
    int deff = (d == 0) ? 1 : d;
    return 2 + (((fe >= fs) ? fe - fs : fs - fe) + 1) * deff;
  endfunction

  task automatic cmp_obs(input string tag, input int t, input obs_t e, input logic [23:0] off);
    check($sformatf("%s t%0d busy", tag, t),   int'(o_busy),   e.busy);
    check($sformatf("%s t%0d enable", tag, t), int'(o_enable), e.enable);
    check($sformatf("%s t%0d done", tag, t),   int'(o_done),   e.done);
    check($sformatf("%s t%0d step", tag, t),   int'(o_step),   e.step);
    check($sformatf("%s t%0d freq", tag, t),   int'(o_freq),   e.freq);
    check($sformatf("%s t%0d offset", tag, t), int'(o_offset), int'(off));
  endtask

  // Starts a sweep at the current negedge (cycle 0) and checks every cycle up to two past DONE.
  task automatic run_sweep(input vec_t v, input bit noise, output int done_cyc, output int steps);
    int   last = last_cycle(v.fs, v.fe, v.d);
    int   lim  = (v.abort_at > 0) ? v.abort_at : last;
    obs_t e;
    i_freq_start = 5'(v.fs); i_freq_stop = 5'(v.fe);
    i_dwell = 16'(v.d); i_offset = v.off; i_start = 1'b1; i_abort = 1'b0;
    done_cyc = 0; steps = 0;
    for (int t = 1; t <= last + 2; t++) begin
      @(negedge i_clk);
      if (v.abort_at > 0 && t > v.abort_at) begin
        e = '{0, 0, 0, 0, model(v.fs, v.fe, v.d, v.abort_at).freq};
        if (t == v.abort_at + 1 && v.abort_at == last) e.freq = v.fe;
      end else begin
        e = model(v.fs, v.fe, v.d, t);
      end
      cmp_obs(v.name, t, e, v.off);
      if (o_done) done_cyc = t;
      if (o_step) steps++;
      i_abort = (t == v.abort_at);
      i_start = noise && (t <= lim) && ($urandom_range(0, 3) == 0);
      if (noise) begin
        i_freq_start = 5'($urandom); i_freq_stop = 5'($urandom);
        i_dwell = 16'($urandom); i_offset = 24'($urandom);
      end
    end
    i_start = 1'b0; i_abort = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int dc, st, fh;
    vec_t rv;

    vecs[0] = '{"up2_5",    2,  5, 4, 24'h400000, 0, 18, 3};
    vecs[1] = '{"down7_4",  7,  4, 1, 24'h123456, 0,  6, 3};
    vecs[2] = '{"dwell0",   3,  5, 0, 24'h00abcd, 0,  5, 2};
    vecs[3] = '{"single9",  9,  9, 3, 24'hffffff, 0,  5, 0};
    vecs[4] = '{"abort4",   2,  5, 4, 24'h400000, 4,  0, 0};
    vecs[5] = '{"down31_0", 31, 0, 1, 24'h000001, 0, 34, 31};
    vecs[6] = '{"up0_31",   0, 31, 2, 24'h800000, 0, 66, 31};

    // Reset state
    #1;
    check("reset freq", int'(o_freq), 0);
    check("reset offset", int'(o_offset), 0);
    check("reset busy/en/step/done", int'({o_busy, o_enable, o_step, o_done}), 0);
    @(negedge i_clk); i_arst = 1'b0;
    @(negedge i_clk);

    foreach (vecs[i]) begin
      run_sweep(vecs[i], 1'b0, dc, st);
      check({vecs[i].name, " done cycle"}, dc, vecs[i].exp_done);
      check({vecs[i].name, " step count"}, st, vecs[i].exp_steps);
    end

    // Abort together with start in IDLE: nothing starts, freq holds.
    fh = int'(o_freq);
    i_freq_start = 5'd12; i_freq_stop = 5'd14; i_dwell = 16'd2; i_start = 1'b1; i_abort = 1'b1;
    @(negedge i_clk); i_start = 1'b0; i_abort = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      check($sformatf("start+abort t%0d busy", t), int'(o_busy), 0);
      check($sformatf("start+abort t%0d enable", t), int'(o_enable), 0);
      check($sformatf("start+abort t%0d freq", t), int'(o_freq), fh);
      @(negedge i_clk);
    end

    // Start repeatedly during RUN is ignored (random noise includes i_start while busy).
    for (int r = 0; r < 25; r++) begin
      rv.name = $sformatf("rand%0d", r);
      rv.fs = $urandom_range(0, 31); rv.fe = $urandom_range(0, 31);
      rv.d = $urandom_range(0, 3); rv.off = 24'($urandom);
      rv.abort_at = ($urandom_range(0, 3) == 0) ?
                    $urandom_range(1, last_cycle(rv.fs, rv.fe, rv.d)) : 0;
      run_sweep(rv, 1'b1, dc, st);
      check({rv.name, " done cycle"}, dc, (rv.abort_at == 0 ||
            rv.abort_at >= last_cycle(rv.fs, rv.fe, rv.d)) ? last_cycle(rv.fs, rv.fe, rv.d) : 0);
    end

    // Asynchronous reset mid-sweep.
    i_freq_start = 5'd2; i_freq_stop = 5'd5; i_dwell = 16'd4; i_offset = 24'h400000; i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
    repeat (7) @(negedge i_clk);
    check("pre-reset enable", int'(o_enable), 1);
    i_arst = 1'b1; #1;
    check("async reset freq", int'(o_freq), 0);
    check("async reset offset", int'(o_offset), 0);
    check("async reset busy/en/step/done", int'({o_busy, o_enable, o_step, o_done}), 0);
    @(negedge i_clk); @(negedge i_clk); i_arst = 1'b0;
    @(negedge i_clk);
    check("post-reset busy", int'(o_busy), 0);
    @(negedge i_clk);
    check("post-reset stays idle", int'({o_busy, o_enable, o_done}), 0);

`ifdef PHASE_SWEEP_LOOP_EN
    // Continuous sweep 0,1,0,1... then clear loop and expect one-shot completion.
    i_freq_start = 5'd0; i_freq_stop = 5'd1; i_dwell = 16'd2; i_loop = 1'b1; i_start = 1'b1;
    for (int t = 1; t <= 14; t++) begin
      @(negedge i_clk);
      i_start = 1'b0;
      if (t == 1) begin
        check("loop arm busy", int'(o_busy), 1);
      end else if (t <= 13) begin
        check($sformatf("loop t%0d enable", t), int'(o_enable), 1);
        check($sformatf("loop t%0d freq", t), int'(o_freq), ((t - 2) / 2) % 2);
        check($sformatf("loop t%0d step", t), int'(o_step), (((t - 2) % 2) == 0 && t > 2) ? 1 : 0);
      end else begin
        check("loop done", int'(o_done), 1);
        check("loop done enable", int'(o_enable), 0);
      end
      if (t == 12) i_loop = 1'b0;
    end
    @(negedge i_clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/phase_sweep_controller.md
# phase_sweep_controller

Sequencer that drives the phase accumulator's frequency code, phase offset and enable to produce stepped frequency sweeps. On a start request it latches a sweep descriptor, presets the accumulator phase, then steps the 5-bit frequency code from a start to a stop value (up or down) with a programmable dwell per step. It sits between the register/command interface and the sin/cos generator, and owns the accumulator's `i_enable`, `i_freq` and `i_offset` inputs.

## Interface
- `DWELL_W`, 16, width of the dwell counter and `i_dwell`.
- `i_clk`  in  1  system clock; all logic on the rising edge.
- `i_arst`  in  1  asynchronous, active-high reset.
- `i_start`  in  1  sweep request; sampled only in IDLE.
- `i_abort`  in  1  stop immediately; valid in any state.
- `i_freq_start`  in  5  first frequency code.
- `i_freq_stop`  in  5  last frequency code.
- `i_dwell`  in  DWELL_W  clocks per step.
- `i_offset`  in  24  initial phase loaded into the accumulator.
- `i_loop`  in  1  continuous-sweep request; present only with `PHASE_SWEEP_LOOP_EN`.
- `o_freq`  out  5  to accumulator `i_freq`.
- `o_offset`  out  24  to accumulator `i_offset`.
- `o_enable`  out  1  to accumulator `i_enable`.
- `o_busy`  out  1  sweep in progress (ARM or RUN).
- `o_step`  out  1  one-cycle strobe on every frequency-code change inside RUN.
- `o_done`  out  1  one-cycle strobe on natural completion.

## Operation
- States: IDLE, ARM, RUN, DONE.
- Reset: all outputs are 0. State is IDLE.
- IDLE → ARM on `i_start`=1 and `i_abort`=0.
  - Latch `i_freq_start`, `i_freq_stop`, `i_dwell` and `i_offset`.
  - Direction is up if start ≤ stop, otherwise down.
  - A dwell of 0 is treated as 1.
- ARM (exactly 1 cycle):
  - `o_freq` = start code, `o_offset` = latched offset, `o_enable` = 0. The accumulator loads the offset.
  - Load the dwell counter with D−1, where D is the latched dwell.
  - Always → RUN.
- RUN: `o_enable` = 1; the counter decrements each cycle. When the counter reaches 0:
  - If `o_freq` ≠ stop: step `o_freq` by ±1, pulse `o_step`, reload D−1, stay in RUN.
  - If `o_freq` = stop: → DONE.
- DONE (1 cycle): `o_done` = 1, `o_enable` = 0, `o_busy` = 0. → IDLE.
- Frequency-code changes during RUN never deassert `o_enable`. Phase stays continuous across steps.
- Start = stop gives a single step of D cycles, with no `o_step` pulse.
- All codes 0..31 are passed through unchanged. Codes whose shifted step exceeds 24 bits are the caller's concern.
- `i_abort` in ARM or RUN:
  - → IDLE next cycle with `o_enable` = 0, `o_busy` = 0.
  - No `o_done` is issued.
  - `o_freq` and `o_offset` hold their last values.
- `i_abort` together with `i_start` in IDLE: abort wins, no sweep starts.
- `i_abort` during DONE: `o_done` still completes.
- `i_start` outside IDLE is ignored.
- Descriptor inputs may change freely after the start cycle.
- Reset asserted mid-sweep: all outputs go to 0 asynchronously and the state returns to IDLE.

## Timing
- Start sampled at cycle 0:
  - Cycle 1: ARM, `o_busy` = 1.
  - Cycle 2: first RUN cycle, `o_enable` = 1.
- Each step holds `o_enable` = 1 for exactly D cycles.
- With N = |stop − start| + 1, `o_done` is high in cycle 2 + N·D.
- `o_step` is high in the first cycle of each new code (cycles 2 + k·D, k = 1..N−1).
- All outputs are registered; there are no combinational input-to-output paths.
- A new `i_start` is accepted in the cycle after DONE at the earliest.

## Configuration
- `PHASE_SWEEP_LOOP_EN` defined:
  - The `i_loop` port exists.
  - At the final expiry with `i_loop` = 1: `o_freq` reloads the start code, `o_step` pulses, and the block stays in RUN with phase continuous (no ARM).
  - With `i_loop` = 0, behaviour is one-shot.
  - `i_loop` is sampled at each final expiry.
- `PHASE_SWEEP_LOOP_EN` undefined: there is no `i_loop` port and sweeps are always one-shot.

## Structure
- The shared package / include file `phase_sweep_pkg` holds:
  - State encodings (IDLE = 0, ARM = 1, RUN = 2, DONE = 3).
  - `FREQ_W` = 5, `ANGLE_W` = 24, and the default `DWELL_W`.
- One sub-module, `dwell_counter`: a load/decrement counter with a zero flag, parameterised by `DWELL_W`.
- The FSM, descriptor latches and frequency stepper stay in `phase_sweep_controller`.

## Test plan
- Reset with sweep active: all outputs 0 immediately. After release, IDLE with `o_busy` = 0.
- Up sweep, start = 2, stop = 5, D = 4, offset = 0x400000:
  - ARM in cycle 1 with `o_offset` = 0x400000 and `o_enable` = 0.
  - Codes 2, 3, 4, 5, each for 4 cycles.
  - `o_step` in cycles 6, 10 and 14.
  - `o_done` in cycle 18.
- Down sweep, start = 7, stop = 4, D = 1: codes 7, 6, 5, 4 in cycles 2–5; `o_done` in cycle 6.
- Edge cases:
  - D = 0 behaves as D = 1.
  - Start = stop = 9, D = 3: no `o_step`, `o_done` in cycle 5.
- Abort and start:
  - Abort at cycle 4 of the up sweep: `o_enable` = 0 and `o_busy` = 0 at cycle 5, no `o_done`, `o_freq` holds.
  - Abort with start in IDLE: nothing happens.
  - Start during RUN: ignored.
- Loop (`PHASE_SWEEP_LOOP_EN`), start = 0, stop = 1, D = 2, `i_loop` = 1:
  - Sequence 0, 1, 0, 1… with `o_step` every 2 cycles and `o_enable` never dropping.
  - Clearing `i_loop` gives `o_done` after the next code-1 step.
